mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: launches one aligned data-memory request per advanced
// EX/MEM instruction, waits for dhit, and hands a registered result to write-back.
module mem_access_stage #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 32,
   parameter int unsigned RW = 5
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              flush,
   input  logic              ihit,
   input  logic              ex_valid,
   input  logic              ex_dREN,
   input  logic              ex_dWEN,
   input  logic [1:0]        ex_size,
   input  logic              ex_unsigned,
   input  logic [AW-1:0]     ex_addr,
   input  logic [DW-1:0]     ex_wdata,
   input  logic [AW-1:0]     ex_nPC,
   input  logic              ex_regWr,
   input  logic [RW-1:0]     ex_regDst,
   input  logic [1:0]        ex_wbSel,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [AW-1:0]     dmemaddr,
   output logic [DW-1:0]     dmemstore,
   output logic [DW/8-1:0]   dmembe,
   input  logic              dhit,
   input  logic [DW-1:0]     dmemload,
   output logic              wb_valid,
   output logic              wb_regWr,
   output logic [RW-1:0]     wb_regDst,
   output logic [1:0]        wb_wbSel,
   output logic [AW-1:0]     wb_ALUOut,
   output logic [AW-1:0]     wb_nPC,
   output logic [DW-1:0]     wb_load,
   output logic              stall,
   output logic              misalign
);
   localparam int unsigned NB   = DW / 8;
   localparam int unsigned LB   = $clog2(NB);
   localparam int unsigned NB2  = NB / 2;
   localparam int unsigned NB4  = NB / 4;
   localparam logic [3:0]  NB_B = 4'(NB);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t          state_q, state_d;
   logic            ren_q, ren_d, wen_q, wen_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   store_q, store_d;
   logic [NB-1:0]   be_q, be_d;
   logic            wbv_q, wbv_d, wbrw_q, wbrw_d;
   logic [RW-1:0]   dst_q, dst_d;
   logic [1:0]      sel_q, sel_d;
   logic [AW-1:0]   alu_q, alu_d, npc_q, npc_d;
   logic [DW-1:0]   load_q, load_d;
   logic            mis_q, mis_d;
   logic [1:0]      size_q, size_d;
   logic            uns_q, uns_d;
   logic [LB-1:0]   off_q, off_d;
   logic            flushed_q, flushed_d;

   logic [3:0]      ex_bytes, ld_bytes;
   logic [2:0]      ex_low;
   logic            ex_bad, ld_sign;
   logic [NB-1:0]   ex_be;
   logic [DW-1:0]   ex_store, ld_shift, ld_mask, ld_value;

   assign stall = (state_q == ACCESS);

   always_comb begin
      ex_bytes = 4'd1 << ex_size;
      ex_low   = 3'(ex_bytes - 4'd1);
      ex_bad   = (ex_bytes > NB_B) || ((ex_addr[2:0] & ex_low) != 3'b000);
      ex_be    = (ex_bytes >= NB_B) ? '1 : (~({NB{1'b1}} << ex_bytes)) << ex_addr[LB-1:0];
      case (ex_size)
         2'b00:   ex_store = {NB{ex_wdata[7:0]}};
         2'b01:   ex_store = {NB2{ex_wdata[15:0]}};
         2'b10:   ex_store = {NB4{ex_wdata[31:0]}};
         default: ex_store = ex_wdata;
      endcase

      // sign bit of the selected field is the top bit of the mask
      ld_shift = dmemload >> {off_q, 3'b000};
      ld_bytes = 4'd1 << size_q;
      ld_mask  = (ld_bytes >= NB_B) ? '1 : ~({DW{1'b1}} << {ld_bytes, 3'b000});
      ld_sign  = ~uns_q & (|(ld_shift & (ld_mask ^ (ld_mask >> 1))));
      ld_value = (ld_shift & ld_mask) | (ld_sign ? ~ld_mask : '0);
   end

   always_comb begin
      state_d   = state_q;
      ren_d     = ren_q;
      wen_d     = wen_q;
      addr_d    = addr_q;
      store_d   = store_q;
      be_d      = be_q;
      wbv_d     = 1'b0;
      wbrw_d    = wbrw_q;
      dst_d     = dst_q;
      sel_d     = sel_q;
      alu_d     = alu_q;
      npc_d     = npc_q;
      load_d    = load_q;
      mis_d     = 1'b0;
      size_d    = size_q;
      uns_d     = uns_q;
      off_d     = off_q;
      flushed_d = flushed_q;

      if (flush && (state_q == IDLE || ren_q)) begin
         state_d   = IDLE;
         ren_d     = 1'b0;
         wen_d     = 1'b0;
         addr_d    = '0;
         store_d   = '0;
         be_d      = '0;
         wbrw_d    = 1'b0;
         dst_d     = '0;
         sel_d     = '0;
         alu_d     = '0;
         npc_d     = '0;
         load_d    = '0;
         size_d    = '0;
         uns_d     = 1'b0;
         off_d     = '0;
         flushed_d = 1'b0;
      end else if (state_q == ACCESS) begin
         // a flushed store still completes on the bus but retires silently
         if (flush) flushed_d = 1'b1;
         if (dhit) begin
            state_d   = IDLE;
            ren_d     = 1'b0;
            wen_d     = 1'b0;
            flushed_d = 1'b0;
            if (flushed_q || flush) wbrw_d = 1'b0;
            else                    wbv_d  = 1'b1;
            if (ren_q) load_d = ld_value;
         end
      end else if (ihit) begin
         wbrw_d = ex_regWr;
         dst_d  = ex_regDst;
         sel_d  = ex_wbSel;
         alu_d  = ex_addr;
         npc_d  = ex_nPC;
         if (!ex_valid) begin
            wbrw_d = 1'b0;
         end else if (!ex_dREN && !ex_dWEN) begin
            wbv_d = 1'b1;
         end else if (ex_bad) begin
            mis_d  = 1'b1;
            wbrw_d = 1'b0;
         end else begin
            state_d   = ACCESS;
            ren_d     = ex_dREN & ~ex_dWEN;
            wen_d     = ex_dWEN;
            addr_d    = {ex_addr[AW-1:LB], {LB{1'b0}}};
            store_d   = ex_store;
            be_d      = ex_be;
            size_d    = ex_size;
            uns_d     = ex_unsigned;
            off_d     = ex_addr[LB-1:0];
            flushed_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= IDLE;
         ren_q     <= 1'b0;
         wen_q     <= 1'b0;
         addr_q    <= '0;
         store_q   <= '0;
         be_q      <= '0;
         wbv_q     <= 1'b0;
         wbrw_q    <= 1'b0;
         dst_q     <= '0;
         sel_q     <= '0;
         alu_q     <= '0;
         npc_q     <= '0;
         load_q    <= '0;
         mis_q     <= 1'b0;
         size_q    <= '0;
         uns_q     <= 1'b0;
         off_q     <= '0;
         flushed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ren_q     <= ren_d;
         wen_q     <= wen_d;
         addr_q    <= addr_d;
         store_q   <= store_d;
         be_q      <= be_d;
         wbv_q     <= wbv_d;
         wbrw_q    <= wbrw_d;
         dst_q     <= dst_d;
         sel_q     <= sel_d;
         alu_q     <= alu_d;
         npc_q     <= npc_d;
         load_q    <= load_d;
         mis_q     <= mis_d;
         size_q    <= size_d;
         uns_q     <= uns_d;
         off_q     <= off_d;
         flushed_q <= flushed_d;
      end
   end

   assign dmemREN   = ren_q;
   assign dmemWEN   = wen_q;
   assign dmemaddr  = addr_q;
   assign dmemstore = store_q;
   assign dmembe    = be_q;
   assign wb_valid  = wbv_q;
   assign wb_regWr  = wbrw_q;
   assign wb_regDst = dst_q;
   assign wb_wbSel  = sel_q;
   assign wb_ALUOut = alu_q;
   assign wb_nPC    = npc_q;
   assign wb_load   = load_q;
   assign misalign  = mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: DW=32 and DW=64 instances share stimulus, each checked
// every cycle against a transaction-level reference model.
module tb_mem_access_stage;

   typedef struct packed {
      logic        flush, ihit, valid, ren, wen;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [31:0] npc;
      logic        regwr;
      logic [4:0]  dst;
      logic [1:0]  sel;
      logic        dhit;
      logic [63:0] load;
   } stim_t;

   typedef struct packed {
      logic        busy, is_load, flushed, uns;
      logic [3:0]  bytes;
      logic [2:0]  off;
      logic        ren, wen;
      logic [31:0] addr;
      logic [63:0] store;
      logic [7:0]  be;
      logic        wbv, wbrw;
      logic [4:0]  dst;
      logic [1:0]  sel;
      logic [31:0] alu, npc;
      logic [63:0] load;
      logic        mis;
   } model_t;

   logic   CLK = 1'b0;
   logic   nRST;
   stim_t  st;
   model_t m32, m64;
   int     errors = 0;
   int     checks = 0;
   int     stall_cnt;

   logic        a_ren, a_wen, a_wbv, a_wbrw, a_stall, a_mis;
   logic [31:0] a_addr, a_store, a_alu, a_npc, a_load;
   logic [3:0]  a_be;
   logic [4:0]  a_dst;
   logic [1:0]  a_sel;
   logic        b_ren, b_wen, b_wbv, b_wbrw, b_stall, b_mis;
   logic [31:0] b_addr, b_alu, b_npc;
   logic [63:0] b_store, b_load;
   logic [7:0]  b_be;
   logic [4:0]  b_dst;
   logic [1:0]  b_sel;

   always #5 CLK = ~CLK;

   mem_access_stage #(.DW(32), .AW(32), .RW(5)) dut32 (
      .CLK(CLK), .nRST(nRST), .flush(st.flush), .ihit(st.ihit),
      .ex_valid(st.valid), .ex_dREN(st.ren), .ex_dWEN(st.wen), .ex_size(st.size),
      .ex_unsigned(st.uns), .ex_addr(st.addr), .ex_wdata(st.wdata[31:0]), .ex_nPC(st.npc),
      .ex_regWr(st.regwr), .ex_regDst(st.dst), .ex_wbSel(st.sel),
      .dmemREN(a_ren), .dmemWEN(a_wen), .dmemaddr(a_addr), .dmemstore(a_store), .dmembe(a_be),
      .dhit(st.dhit), .dmemload(st.load[31:0]),
      .wb_valid(a_wbv), .wb_regWr(a_wbrw), .wb_regDst(a_dst), .wb_wbSel(a_sel),
      .wb_ALUOut(a_alu), .wb_nPC(a_npc), .wb_load(a_load), .stall(a_stall), .misalign(a_mis)
   );

   mem_access_stage #(.DW(64), .AW(32), .RW(5)) dut64 (
      .CLK(CLK), .nRST(nRST), .flush(st.flush), .ihit(st.ihit),
      .ex_valid(st.valid), .ex_dREN(st.ren), .ex_dWEN(st.wen), .ex_size(st.size),
      .ex_unsigned(st.uns), .ex_addr(st.addr), .ex_wdata(st.wdata), .ex_nPC(st.npc),
      .ex_regWr(st.regwr), .ex_regDst(st.dst), .ex_wbSel(st.sel),
      .dmemREN(b_ren), .dmemWEN(b_wen), .dmemaddr(b_addr), .dmemstore(b_store), .dmembe(b_be),
      .dhit(st.dhit), .dmemload(st.load),
      .wb_valid(b_wbv), .wb_regWr(b_wbrw), .wb_regDst(b_dst), .wb_wbSel(b_sel),
      .wb_ALUOut(b_alu), .wb_nPC(b_npc), .wb_load(b_load), .stall(b_stall), .misalign(b_mis)
   );

   // pick `bytes` bytes starting at lane `off`, then extend to nb bytes
   function automatic logic [63:0] extract(logic [63:0] d, int unsigned nb, int unsigned off,
                                           int unsigned bytes, logic uns);
      logic [63:0] v;
      v = '0;
      for (int unsigned k = 0; k < bytes; k++)
         v = v | (((d >> (8 * (off + k))) & 64'hFF) << (8 * k));
      if (!uns && v[8 * bytes - 1])
         for (int unsigned k = bytes; k < nb; k++)
            v = v | (64'hFF << (8 * k));
      return v;
   endfunction

   function automatic model_t step(model_t m, int unsigned nb, stim_t s);
      model_t      n;
      int unsigned by;
      n     = m;
      n.wbv = 1'b0;
      n.mis = 1'b0;
      by    = 1 << s.size;
      if (s.flush && (!m.busy || m.is_load)) return '0;
      if (m.busy) begin
         if (s.flush) n.flushed = 1'b1;
         if (s.dhit) begin
            n.busy = 1'b0; n.ren = 1'b0; n.wen = 1'b0; n.flushed = 1'b0;
            if (m.flushed || s.flush) n.wbrw = 1'b0;
            else                      n.wbv  = 1'b1;
            if (m.is_load) n.load = extract(s.load, nb, m.off, m.bytes, m.uns);
         end
      end else if (s.ihit) begin
         n.wbrw = s.regwr; n.dst = s.dst; n.sel = s.sel; n.alu = s.addr; n.npc = s.npc;
         if (!s.valid) n.wbrw = 1'b0;
         else if (!s.ren && !s.wen) n.wbv = 1'b1;
         else if (by > nb || (s.addr % by) != 0) begin
            n.mis = 1'b1; n.wbrw = 1'b0;
         end else begin
            n.busy = 1'b1; n.is_load = !s.wen; n.ren = !s.wen; n.wen = s.wen;
            n.flushed = 1'b0; n.uns = s.uns; n.bytes = 4'(by); n.off = 3'(s.addr % nb);
            n.addr = s.addr - (s.addr % nb);
            n.be = '0; n.store = '0;
            for (int unsigned i = 0; i < nb; i++) begin
               n.be[i] = (i >= n.off) && (i < n.off + by);
               n.store[8*i +: 8] = s.wdata[8*(i % by) +: 8];
            end
         end
      end
      return n;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("a_ren", 64'(a_ren), 64'(m32.ren));       chk("a_wen", 64'(a_wen), 64'(m32.wen));
      chk("a_addr", 64'(a_addr), 64'(m32.addr));    chk("a_store", 64'(a_store), m32.store);
      chk("a_be", 64'(a_be), 64'(m32.be));          chk("a_wbv", 64'(a_wbv), 64'(m32.wbv));
      chk("a_wbrw", 64'(a_wbrw), 64'(m32.wbrw));    chk("a_dst", 64'(a_dst), 64'(m32.dst));
      chk("a_sel", 64'(a_sel), 64'(m32.sel));       chk("a_alu", 64'(a_alu), 64'(m32.alu));
      chk("a_npc", 64'(a_npc), 64'(m32.npc));       chk("a_load", 64'(a_load), m32.load);
      chk("a_stall", 64'(a_stall), 64'(m32.busy));  chk("a_mis", 64'(a_mis), 64'(m32.mis));
      chk("b_ren", 64'(b_ren), 64'(m64.ren));       chk("b_wen", 64'(b_wen), 64'(m64.wen));
      chk("b_addr", 64'(b_addr), 64'(m64.addr));    chk("b_store", b_store, m64.store);
      chk("b_be", 64'(b_be), 64'(m64.be));          chk("b_wbv", 64'(b_wbv), 64'(m64.wbv));
      chk("b_wbrw", 64'(b_wbrw), 64'(m64.wbrw));    chk("b_dst", 64'(b_dst), 64'(m64.dst));
      chk("b_sel", 64'(b_sel), 64'(m64.sel));       chk("b_alu", 64'(b_alu), 64'(m64.alu));
      chk("b_npc", 64'(b_npc), 64'(m64.npc));       chk("b_load", b_load, m64.load);
      chk("b_stall", 64'(b_stall), 64'(m64.busy));  chk("b_mis", 64'(b_mis), 64'(m64.mis));
   endtask

   task automatic cyc();
      m32 = step(m32, 4, st);
      m64 = step(m64, 8, st);
      @(posedge CLK);
      #1;
      check_all();
   endtask

   task automatic mid_reset();
      #2;
      nRST = 1'b0;
      m32  = '0;
      m64  = '0;
      #1;
      check_all();
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   function automatic stim_t op(logic ren, logic wen, logic [1:0] size, logic uns,
                                logic [31:0] addr, logic [63:0] wdata, logic regwr);
      stim_t s;
      s = '0;
      s.ihit = 1'b1; s.valid = 1'b1; s.ren = ren; s.wen = wen; s.size = size; s.uns = uns;
      s.addr = addr; s.wdata = wdata; s.regwr = regwr; s.npc = addr + 32'd4;
      s.dst = 5'd7; s.sel = 2'b01;
      return s;
   endfunction

   initial begin
      nRST = 1'b0;
      st   = '0;
      m32  = '0;
      m64  = '0;
      #7;
      check_all();
      @(negedge CLK);
      nRST = 1'b1;

      // lw 0x100, dhit two cycles after the request
      st = op(1, 0, 2'b10, 0, 32'h100, 64'h0, 1);
      cyc(); stall_cnt = int'(a_stall);
      chk("lw_req", 64'(a_ren), 64'd1);
      st.ihit = 1'b0;
      cyc(); stall_cnt += int'(a_stall);
      cyc(); stall_cnt += int'(a_stall);
      st.dhit = 1'b1; st.load = 64'hDEADBEEF;
      cyc(); stall_cnt += int'(a_stall);
      chk("lw_stall_cycles", 64'(stall_cnt), 64'd3);
      chk("lw_wbv", 64'(a_wbv), 64'd1);
      chk("lw_load", 64'(a_load), 64'hDEADBEEF);
      st.dhit = 1'b0;
      cyc();
      chk("lw_wbv_pulse", 64'(a_wbv), 64'd0);
      chk("lw_load_hold", 64'(a_load), 64'hDEADBEEF);

      // lb / lbu 0x103
      st = op(1, 0, 2'b00, 0, 32'h103, 64'h0, 1);
      cyc();
      chk("lb_be", 64'(a_be), 64'b1000);
      chk("lb_addr", 64'(a_addr), 64'h100);
      st.ihit = 1'b0; st.dhit = 1'b1; st.load = 64'h80FF0000;
      cyc();
      chk("lb_load", 64'(a_load), 64'hFFFFFF80);
      st = op(1, 0, 2'b00, 1, 32'h103, 64'h0, 1);
      cyc();
      st.ihit = 1'b0; st.dhit = 1'b1; st.load = 64'h80FF0000;
      cyc();
      chk("lbu_load", 64'(a_load), 64'h80);

      // sh 0x102
      st = op(0, 1, 2'b01, 0, 32'h102, 64'h1234ABCD, 0);
      cyc();
      chk("sh_wen", 64'(a_wen), 64'd1);
      chk("sh_be", 64'(a_be), 64'b1100);
      chk("sh_store", 64'(a_store), 64'hABCDABCD);
      chk("sh_wbrw", 64'(a_wbrw), 64'd0);
      st.ihit = 1'b0; st.dhit = 1'b1;
      cyc();
      chk("sh_done", 64'(a_wbv), 64'd1);

      // misaligned word, illegal double on DW=32
      st = op(1, 0, 2'b10, 0, 32'h102, 64'h0, 1);
      cyc();
      chk("mis_flag", 64'(a_mis), 64'd1);
      chk("mis_ren", 64'(a_ren), 64'd0);
      chk("mis_stall", 64'(a_stall), 64'd0);
      st.ihit = 1'b0;
      cyc();
      chk("mis_pulse", 64'(a_mis), 64'd0);
      st = op(1, 0, 2'b11, 0, 32'h100, 64'h0, 1);
      cyc();
      chk("dbl32_mis", 64'(a_mis), 64'd1);
      chk("dbl64_req", 64'(b_ren), 64'd1);
      st.ihit = 1'b0; st.dhit = 1'b1;
      cyc();

      // flush during load, then during store
      st = op(1, 0, 2'b10, 0, 32'h200, 64'h0, 1);
      cyc();
      st.ihit = 1'b0; st.flush = 1'b1;
      cyc();
      chk("fl_ld_ren", 64'(a_ren), 64'd0);
      chk("fl_ld_stall", 64'(a_stall), 64'd0);
      st = op(0, 1, 2'b10, 0, 32'h204, 64'h55667788, 1);
      cyc();
      st.ihit = 1'b0; st.flush = 1'b1;
      cyc();
      chk("fl_st_wen", 64'(a_wen), 64'd1);
      chk("fl_st_stall", 64'(a_stall), 64'd1);
      st.flush = 1'b0; st.dhit = 1'b1;
      cyc();
      chk("fl_st_wbv", 64'(a_wbv), 64'd0);
      chk("fl_st_wbrw", 64'(a_wbrw), 64'd0);
      st.dhit = 1'b0;
      cyc();

      // reset mid-access, then 64-bit ld at 0x08
      st = op(1, 0, 2'b10, 0, 32'h100, 64'h0, 1);
      cyc();
      st.ihit = 1'b0;
      mid_reset();
      chk("rst_stall", 64'(a_stall), 64'd0);
      chk("rst_ren", 64'(a_ren), 64'd0);
      st = op(1, 0, 2'b11, 0, 32'h08, 64'h0, 1);
      cyc();
      chk("ld64_be", 64'(b_be), 64'hFF);
      chk("ld64_addr", 64'(b_addr), 64'h08);
      st.ihit = 1'b0; st.dhit = 1'b1; st.load = 64'h0123456789ABCDEF;
      cyc();
      chk("ld64_load", b_load, 64'h0123456789ABCDEF);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         st       = '0;
         st.flush = ($urandom_range(0, 11) == 0);
         st.ihit  = ($urandom_range(0, 9) < 7);
         st.valid = ($urandom_range(0, 7) != 0);
         st.ren   = 1'($urandom_range(0, 1));
         st.wen   = 1'($urandom_range(0, 1));
         st.size  = 2'($urandom_range(0, 3));
         st.uns   = 1'($urandom_range(0, 1));
         st.addr  = $urandom;
         if ($urandom_range(0, 3) != 0) st.addr = st.addr & ~((32'd1 << st.size) - 32'd1);
         st.wdata = {$urandom, $urandom};
         st.npc   = $urandom;
         st.regwr = 1'($urandom_range(0, 1));
         st.dst   = 5'($urandom_range(0, 31));
         st.sel   = 2'($urandom_range(0, 3));
         st.dhit  = ($urandom_range(0, 9) < 4);
         st.load  = {$urandom, $urandom};
         cyc();
         if ($urandom_range(0, 149) == 0) mid_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
